// File: rtl/deskew_pkg.sv
// Shared types and constants for the lane deskew controller.
package deskew_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      MEASURE,
      LOCKED,
      FAIL
   } state_t;

   localparam logic [7:0] COM = 8'hBC;

   // Width of a tap select able to hold 0..max_skew; never narrower than one bit.
   function automatic int skew_w(input int max_skew);
      return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
   endfunction

endpackage

// File: rtl/deskew_lane_tracker.sv
// Per-lane arrival recorder: latches the relative cycle of the first marker seen while enabled.
module deskew_lane_tracker
   import deskew_pkg::*;
#(
   parameter int                 BITDATA = 8,
   parameter int                 SKEW_W  = 3,
   parameter logic [BITDATA-1:0] MARKER  = COM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [BITDATA-1:0] din,
   input  logic [SKEW_W-1:0]  cnt,
   output logic               seen,
   output logic [SKEW_W-1:0]  arrival
);

   logic              seen_q, seen_d;
   logic [SKEW_W-1:0] arrival_q, arrival_d;

   always_comb begin
      seen_d    = seen_q;
      arrival_d = arrival_q;
      if (clr) begin
         seen_d    = 1'b0;
         arrival_d = '0;
      end else if (en && !seen_q && (din == MARKER)) begin
         seen_d    = 1'b1;
         arrival_d = cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seen_q    <= 1'b0;
         arrival_q <= '0;
      end else begin
         seen_q    <= seen_d;
         arrival_q <= arrival_d;
      end
   end

   assign seen    = seen_q;
   assign arrival = arrival_q;

endmodule

// File: rtl/lane_deskew_ctrl.sv
// Measures inter-lane marker skew and programs per-lane delay taps so all lanes leave aligned.
// Optional SEARCH watchdog enabled by defining DESKEW_TIMEOUT_EN.
module lane_deskew_ctrl
   import deskew_pkg::*;
#(
   parameter int                 NUM_LANES = 4,
   parameter int                 BITDATA   = 8,
   parameter int                 MAX_SKEW  = 7,
   parameter logic [BITDATA-1:0] MARKER    = COM,
   parameter int                 TIMEOUT   = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_LANES*BITDATA-1:0]            din,
   input  logic                                    start,
   output logic [NUM_LANES*skew_w(MAX_SKEW)-1:0]   delay_sel,
   output logic                                    locked,
   output logic                                    err,
   output logic                                    busy
);

   localparam int                SKEW_W   = skew_w(MAX_SKEW);
   localparam logic [SKEW_W-1:0] LAST_CNT = SKEW_W'(MAX_SKEW);

   if (NUM_LANES < 1 || MAX_SKEW < 1 || TIMEOUT < 1) begin : g_param_check
      $error("lane_deskew_ctrl: NUM_LANES, MAX_SKEW and TIMEOUT must all be >= 1");
   end

   state_t                      state_q, state_d;
   logic [SKEW_W-1:0]           cnt_q, cnt_d;
   logic [NUM_LANES*SKEW_W-1:0] delay_sel_q, delay_sel_d;
   logic                        locked_q, locked_d;
   logic                        err_q, err_d;
   logic                        busy_q, busy_d;

   logic                        trk_clr, trk_en;
   logic [NUM_LANES-1:0]        hit, seen;
   logic [SKEW_W-1:0]           arrival [NUM_LANES];
   logic                        wd_expired;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign hit[i] = (din[i*BITDATA +: BITDATA] == MARKER);

      deskew_lane_tracker #(
         .BITDATA (BITDATA),
         .SKEW_W  (SKEW_W),
         .MARKER  (MARKER)
      ) u_tracker (
         .clk     (clk),
         .rst     (rst),
         .clr     (trk_clr),
         .en      (trk_en),
         .din     (din[i*BITDATA +: BITDATA]),
         .cnt     (cnt_q),
         .seen    (seen[i]),
         .arrival (arrival[i])
      );
   end

`ifdef DESKEW_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // Counts SEARCH cycles only; any other state holds it at zero so entry starts fresh.
   always_comb begin
      wd_d = '0;
      if (state_q == SEARCH) wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end

   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      delay_sel_d = delay_sel_q;
      trk_clr     = 1'b0;
      trk_en      = 1'b0;
      case (state_q)
         IDLE, LOCKED, FAIL: begin
            if (start) begin
               state_d = SEARCH;
               cnt_d   = '0;
               trk_clr = 1'b1;
            end
         end
         SEARCH: begin
            trk_en = 1'b1;
            if (|hit) begin
               if (&hit) begin
                  state_d     = LOCKED;
                  delay_sel_d = '0;
               end else begin
                  state_d = MEASURE;
                  cnt_d   = SKEW_W'(1);
               end
            end else if (wd_expired) begin
               state_d = FAIL;
            end
         end
         MEASURE: begin
            trk_en = 1'b1;
            cnt_d  = cnt_q + SKEW_W'(1);
            // Lanes arriving this cycle count as arrival == cnt, so their delay is zero.
            if (&(seen | hit)) begin
               state_d = LOCKED;
               for (int i = 0; i < NUM_LANES; i++) begin
                  delay_sel_d[i*SKEW_W +: SKEW_W] = seen[i] ? (cnt_q - arrival[i]) : '0;
               end
            end else if (cnt_q == LAST_CNT) begin
               state_d = FAIL;
            end
         end
         default: state_d = IDLE;
      endcase

      locked_d = (state_d == LOCKED);
      err_d    = (state_d == FAIL);
      busy_d   = (state_d == SEARCH) || (state_d == MEASURE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         delay_sel_q <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         delay_sel_q <= delay_sel_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign delay_sel = delay_sel_q;
   assign locked    = locked_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Bench for lane_deskew_ctrl: directed table, hand sequences and random marker streams vs a first-arrival model.
module tb_lane_deskew_ctrl;

   localparam int NL   = 4;
   localparam int BD   = 8;
   localparam int MS   = 7;
   localparam int SW   = 3;
   localparam int SLEN = 24;
   localparam logic [7:0] MK = 8'hBC;

   logic             clk = 1'b0;
   logic             rst;
   logic [NL*BD-1:0] din;
   logic             start;
   logic [NL*SW-1:0] delay_sel;
   logic             locked, err, busy;

   always #5 clk = ~clk;

   lane_deskew_ctrl #(
      .NUM_LANES (NL),
      .BITDATA   (BD),
      .MAX_SKEW  (MS),
      .MARKER    (MK),
      .TIMEOUT   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .start     (start),
      .delay_sel (delay_sel),
      .locked    (locked),
      .err       (err),
      .busy      (busy)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [NL*SW-1:0] prev_sel;
   logic [7:0]       strm [NL][SLEN];

   typedef struct {
      int         o0, o1, o2, o3;
      logic       el;
      logic       ee;
      logic [11:0] es;
      int         lat;
   } vec_t;

   vec_t tbl [7];

   function automatic logic [7:0] filler();
      logic [7:0] v;
      do v = 8'($urandom); while (v == MK);
      return v;
   endfunction

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_din();
      for (int i = 0; i < NL; i++) din[i*BD +: BD] = filler();
   endtask

   task automatic load_offsets(input int o0, input int o1, input int o2, input int o3);
      int o [NL];
      o[0] = o0; o[1] = o1; o[2] = o2; o[3] = o3;
      for (int i = 0; i < NL; i++)
         for (int j = 0; j < SLEN; j++)
            strm[i][j] = (j == o[i]) ? MK : filler();
   endtask

   // First-arrival reference: earliest marker per lane relative to the earliest marker overall.
   task automatic model(output logic el, output logic ee, output logic [11:0] es, output int lat);
      int first [NL];
      int t0, k, rel;
      bit ok;
      t0 = SLEN;
      for (int i = 0; i < NL; i++) begin
         first[i] = -1;
         for (int j = 0; j < SLEN; j++)
            if (first[i] < 0 && strm[i][j] == MK) first[i] = j;
         if (first[i] >= 0 && first[i] < t0) t0 = first[i];
      end
      ok = 1; k = 0;
      for (int i = 0; i < NL; i++) begin
         if (first[i] < 0 || first[i] - t0 > MS) ok = 0;
         else if (first[i] - t0 > k) k = first[i] - t0;
      end
      es = prev_sel;
      if (ok) begin
         el = 1'b1; ee = 1'b0; lat = t0 + k + 1;
         for (int i = 0; i < NL; i++) begin
            rel = first[i] - t0;
            es[i*SW +: SW] = SW'(k - rel);
         end
      end else begin
         el = 1'b0; ee = 1'b1; lat = t0 + MS + 1;
      end
   endtask

   task automatic run_check(input string name, input logic el, input logic ee,
                            input logic [11:0] es, input int exp_lat);
      int lat;
      bit done;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check1({name, " busy after start"}, busy, 1);
      check1({name, " locked after start"}, locked, 0);
      check1({name, " err after start"}, err, 0);
      done = 0; lat = 0;
      for (int j = 0; j < SLEN && !done; j++) begin
         for (int i = 0; i < NL; i++) din[i*BD +: BD] = strm[i][j];
         @(negedge clk);
         if (!busy) begin
            done = 1; lat = j + 1;
         end else begin
            check1({name, " locked while busy"}, locked, 0);
            check1({name, " err while busy"}, err, 0);
            check1({name, " delay_sel held while busy"}, delay_sel, prev_sel);
         end
      end
      idle_din();
      if (!done) begin
         n_vec++; n_bad++;
         $display("FAIL %s timeout: still busy after %0d cycles, required done by %0d", name, SLEN, exp_lat);
      end else begin
         check1({name, " latency"}, lat, exp_lat);
         check1({name, " locked"}, locked, el);
         check1({name, " err"}, err, ee);
         check1({name, " delay_sel"}, delay_sel, es);
      end
      prev_sel = es;
   endtask

   initial begin
      #2000000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic el, ee;
      logic [11:0] es;
      int lat, pre;

      tbl[0] = '{0, 2, 5, 1,  1'b1, 1'b0, {3'd4, 3'd0, 3'd3, 3'd5}, 6};
      tbl[1] = '{0, 1, 3, -1, 1'b0, 1'b1, {3'd4, 3'd0, 3'd3, 3'd5}, 8};
      tbl[2] = '{0, 0, 1, 0,  1'b1, 1'b0, {3'd1, 3'd0, 3'd1, 3'd1}, 2};
      tbl[3] = '{0, 0, 0, 0,  1'b1, 1'b0, {3'd0, 3'd0, 3'd0, 3'd0}, 1};
      tbl[4] = '{7, 0, 3, 2,  1'b1, 1'b0, {3'd5, 3'd4, 3'd7, 3'd0}, 8};
      tbl[5] = '{0, 8, 1, 1,  1'b0, 1'b1, {3'd5, 3'd4, 3'd7, 3'd0}, 8};
      tbl[6] = '{3, 4, 5, 6,  1'b1, 1'b0, {3'd0, 3'd1, 3'd2, 3'd3}, 7};

      rst = 1'b1; start = 1'b0; idle_din();
      repeat (2) @(negedge clk);
      check1("reset busy", busy, 0);
      check1("reset locked", locked, 0);
      check1("reset err", err, 0);
      check1("reset delay_sel", delay_sel, 0);
      rst = 1'b0;
      prev_sel = '0;

      for (int t = 0; t < 7; t++) begin
         load_offsets(tbl[t].o0, tbl[t].o1, tbl[t].o2, tbl[t].o3);
         run_check($sformatf("table%0d", t), tbl[t].el, tbl[t].ee, tbl[t].es, tbl[t].lat);
      end

      // Reset while measuring at cnt=3 must abort with all outputs cleared.
      load_offsets(0, 5, 6, -1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < NL; i++) din[i*BD +: BD] = strm[i][j];
         if (j == 3) rst = 1'b1;
         @(negedge clk);
      end
      rst = 1'b0; idle_din();
      check1("midreset busy", busy, 0);
      check1("midreset locked", locked, 0);
      check1("midreset err", err, 0);
      check1("midreset delay_sel", delay_sel, 0);
      prev_sel = '0;
      load_offsets(0, 2, 5, 1);
      run_check("after_reset", 1'b1, 1'b0, {3'd4, 3'd0, 3'd3, 3'd5}, 6);

      for (int r = 0; r < 40; r++) begin
         pre = $urandom_range(0, 4);
         for (int i = 0; i < NL; i++)
            for (int j = 0; j < SLEN; j++)
               strm[i][j] = (j >= pre && j < pre + 10 && $urandom_range(0, 4) == 0) ? MK : filler();
         strm[$urandom_range(0, NL - 1)][pre] = MK;
         model(el, ee, es, lat);
         run_check($sformatf("random%0d", r), el, ee, es, lat);
      end

      // No marker at all after start.
      idle_din();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
`ifdef DESKEW_TIMEOUT_EN
      repeat (15) begin
         idle_din();
         @(negedge clk);
      end
      check1("watchdog err before expiry", err, 0);
      check1("watchdog busy before expiry", busy, 1);
      idle_din();
      @(negedge clk);
      check1("watchdog err at expiry", err, 1);
      check1("watchdog busy at expiry", busy, 0);
`else
      repeat (100) begin
         idle_din();
         @(negedge clk);
      end
      check1("no-marker busy after 100", busy, 1);
      check1("no-marker err after 100", err, 0);
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check1("final reset busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/lane_deskew_ctrl.md
Name: lane_deskew_ctrl

Overview:
- Controller that measures inter-lane skew on a multi-lane PCIe receive path.
- Watches raw per-lane symbols for an alignment marker (COM) and records each lane's arrival offset.
- Programs per-lane delay tap selects for the downstream fixed/variable delay lines so that all lanes leave aligned.
- Sits between the lane receivers and the per-lane delay pipelines; reports lock or failure to link training.

Parameters:
- NUM_LANES, 4, number of lanes handled.
- BITDATA, 8, symbol width per lane.
- MAX_SKEW, 7, largest correctable skew in cycles; SKEW_W = $clog2(MAX_SKEW+1).
- MARKER, 8'hBC, alignment symbol value (COM).
- TIMEOUT, 16, SEARCH watchdog in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din  in  NUM_LANES*BITDATA  raw lane symbols; lane i is din[i*BITDATA +: BITDATA].
- start  in  1  single-cycle pulse that begins or restarts deskew.
- delay_sel  out  NUM_LANES*SKEW_W  per-lane tap select; lane i is delay_sel[i*SKEW_W +: SKEW_W].
- locked  out  1  deskew complete and delay_sel valid.
- err  out  1  deskew failed (skew > MAX_SKEW, or timeout).
- busy  out  1  high in SEARCH or MEASURE.

Behaviour:
- Reset: on the clk edge with rst=1, state=IDLE, delay_sel=0, locked=0, err=0, busy=0, arrival records cleared. Reset mid-operation aborts immediately, with no partial update to delay_sel.
- States: IDLE, SEARCH, MEASURE, LOCKED, FAIL. All outputs are registered.
- IDLE: start goes to SEARCH.
- LOCKED or FAIL: start goes to SEARCH and clears locked and err on the next cycle. delay_sel is held at its old value until a new lock, so the datapath stays stable. start in SEARCH or MEASURE is ignored.
- SEARCH: wait for any lane with din lane == MARKER.
  - On that cycle, the relative counter cnt is 0; every lane showing MARKER records arrival=0.
  - If all lanes match in that same cycle, go directly to LOCKED with all delays 0.
  - Otherwise go to MEASURE with cnt=1 on the next cycle.
- MEASURE: cnt increments by 1 per cycle.
  - A lane not yet recorded that shows MARKER records arrival=cnt. Later markers on a recorded lane are ignored.
  - When the last lane records at cnt=k: delay_sel[i] = k - arrival[i] (unsigned, never negative), locked=1, state=LOCKED; all take effect on the next edge.
  - If cnt == MAX_SKEW and some lane is still unrecorded after this cycle's arrivals: err=1, state=FAIL, delay_sel unchanged.
  - Lanes arriving on exactly cnt==MAX_SKEW complete normally.
- Latency: locked rises on the edge following the final marker cycle.
- busy=1 exactly while in SEARCH or MEASURE.
- NUM_LANES=1: first marker locks with delay 0.

Optional Feature:
- Macro: DESKEW_TIMEOUT_EN.
- Defined: a watchdog counts cycles in SEARCH. If TIMEOUT cycles elapse with no marker, err=1 and state=FAIL. The watchdog clears on entry to SEARCH.
- Undefined: SEARCH waits indefinitely, TIMEOUT is unused, and no watchdog logic is synthesised.

Decomposition:
- Package deskew_pkg holds:
  - the state enum (IDLE, SEARCH, MEASURE, LOCKED, FAIL);
  - the COM marker constant 8'hBC;
  - a helper function for the SKEW_W computation.
- One sub-module, deskew_lane_tracker, instantiated per lane. It holds the seen flag and arrival register, takes din lane, cnt, a clear and an enable, and outputs seen and arrival.
- The FSM and the delay computation stay in lane_deskew_ctrl.

Test Plan:
- Markers on lanes 0,1,2,3 at relative cycles 0,2,5,1 -> one cycle after lane 2's marker, locked=1 and delay_sel lanes 0..3 = 5,3,0,4; err=0, busy=0.
- All four lanes show 8'hBC in the same cycle after start -> locked=1 next edge, all delay_sel=0, MEASURE never entered.
- Lanes 0-2 see the marker at cycles 0,1,3 and lane 3 never does -> err=1 on the edge after cnt=7, locked=0, delay_sel keeps prior values.
- rst asserted during MEASURE (cnt=3) -> next edge state=IDLE, all outputs 0; subsequent start runs a fresh deskew correctly.
- From LOCKED (delays 5,3,0,4), pulse start, then markers at 0,0,1,0 -> locked drops the cycle after start, delay_sel holds 5,3,0,4 until the new lock, then becomes 1,1,0,1.
- DESKEW_TIMEOUT_EN defined, TIMEOUT=16, start with no marker -> err=1 exactly 16 cycles after SEARCH entry. With the macro undefined -> still busy with err=0 after 100 cycles.
